// File: rtl/ct_f_spsram_pkg.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_pkg
// Shared definitions for the single-port SRAM wrapper with power-on clear:
// default geometry parameters and the controller state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package ct_f_spsram_pkg;

   localparam int DEF_WIDTH      = 54;
   localparam int DEF_ADDR_WIDTH = 8;
   localparam int DEF_SLICE      = 27;

   // CLEAR sweeps zeros into every entry after reset, READY serves user accesses
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } sram_state_e;

endpackage

// File: rtl/fpga_ram.sv
// ----------------------------------------------------------------------------
// fpga_ram
// Simple synchronous single-port RAM, write-first: on a write cycle the output
// register takes the new data, otherwise it takes the addressed entry.
// Ports:
//   CLK  - clock, rising edge
//   we   - active-high write enable
//   addr - address (2^ADDR_WIDTH entries)
//   din  - write data
//   dout - registered read data
// ----------------------------------------------------------------------------
module fpga_ram #(
   parameter int DATA_WIDTH = 27,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write-first so a write is visible on dout the very next cycle
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= din;
         dout      <= din;
      end else begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/ct_f_spsram_param_init.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_param_init
// Slice-write-enabled single-port SRAM that clears itself to zero after reset.
// A sweep counter writes zero to every address (one per cycle) while BUSY is
// high; afterwards user accesses are accepted.
// Optional feature macro: CT_F_SPSRAM_PARITY_EN adds one even-parity bit per
// slice and drives PERR on reads whose stored parity does not match.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset, restarts the clear sweep
//   CEN  - active-low chip enable
//   GWEN - active-low global write enable
//   WEN  - active-low write mask, only each slice's MSB bit is used
//   A    - address
//   D    - write data
//   Q    - read data (one cycle latency, held while idle)
//   BUSY - high during the clear sweep
//   PERR - read parity error (always 0 without the parity macro)
// ----------------------------------------------------------------------------
module ct_f_spsram_param_init
   import ct_f_spsram_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int SLICE      = DEF_SLICE
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [WIDTH-1:0]      WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [WIDTH-1:0]      D,
   output logic [WIDTH-1:0]      Q,
   output logic                  BUSY,
   output logic                  PERR
);

   localparam int NSLICE = WIDTH / SLICE;
`ifdef CT_F_SPSRAM_PARITY_EN
   localparam int RAM_W = SLICE + 1;
`else
   localparam int RAM_W = SLICE;
`endif

   if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("WIDTH must be an integer multiple of SLICE");
   end

   sram_state_e           state;
   logic [ADDR_WIDTH-1:0] sweep_cnt;
   logic [ADDR_WIDTH-1:0] hold_addr;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  busy;
   logic                  accept;
   logic                  acc_write;
   logic                  rd_valid;
   logic                  wen_unused;

   assign busy      = (state == CLEAR);
   assign BUSY      = busy;
   // Nothing is accepted in the reset cycle so reset never races a user write
   assign accept    = !RST && !busy && !CEN;
   assign acc_write = accept && !GWEN;
   // Idle cycles re-read the held address, which keeps Q stable
   assign ram_addr  = busy ? sweep_cnt : (accept ? A : hold_addr);
   assign wen_unused = ^WEN;

   // Controller: clear sweep, then capture address / read-valid per access.
   // The counter stops at the last entry instead of wrapping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= CLEAR;
         sweep_cnt <= '0;
         hold_addr <= '0;
         rd_valid  <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (&sweep_cnt) begin
                  state <= READY;
               end else begin
                  sweep_cnt <= sweep_cnt + 1'b1;
               end
            end
            READY: begin
               if (accept) begin
                  hold_addr <= A;
                  rd_valid  <= GWEN;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   logic [NSLICE-1:0] slice_perr;

   for (genvar k = 0; k < NSLICE; k++) begin : g_slice
      logic             we_k;
      logic [SLICE-1:0] wdata;
      logic [RAM_W-1:0] din_k;
      logic [RAM_W-1:0] dout_k;

      assign wdata = D[k*SLICE +: SLICE];
      assign we_k  = !RST && (busy || (acc_write && !WEN[k*SLICE+SLICE-1]));
`ifdef CT_F_SPSRAM_PARITY_EN
      assign din_k         = busy ? '0 : {^wdata, wdata};
      assign slice_perr[k] = ^dout_k;
`else
      assign din_k         = busy ? '0 : wdata;
      assign slice_perr[k] = 1'b0;
`endif

      fpga_ram #(
         .DATA_WIDTH(RAM_W),
         .ADDR_WIDTH(ADDR_WIDTH)
      ) u_ram (
         .CLK (CLK),
         .we  (we_k),
         .addr(ram_addr),
         .din (din_k),
         .dout(dout_k)
      );

      assign Q[k*SLICE +: SLICE] = dout_k[SLICE-1:0];
   end

`ifdef CT_F_SPSRAM_PARITY_EN
   assign PERR = !busy && rd_valid && (|slice_perr);
`else
   logic perr_unused;
   assign perr_unused = rd_valid ^ (|slice_perr);
   assign PERR        = 1'b0;
`endif

endmodule

// File: tb/tb_ct_f_spsram_param_init.sv
// ----------------------------------------------------------------------------
// tb_ct_f_spsram_param_init
// Self-checking bench: a word-level model of the memory produces expected
// read data that is queued when a read is driven and compared when Q is due.
// ----------------------------------------------------------------------------
module tb_ct_f_spsram_param_init;

   localparam int WIDTH      = 54;
   localparam int ADDR_WIDTH = 8;
   localparam int SLICE      = 27;
   localparam int NSLICE     = WIDTH / SLICE;
   localparam int DEPTH      = 256;

   logic                  CLK = 1'b0;
   logic                  RST;
   logic                  CEN;
   logic                  GWEN;
   logic [WIDTH-1:0]      WEN;
   logic [ADDR_WIDTH-1:0] A;
   logic [WIDTH-1:0]      D;
   logic [WIDTH-1:0]      Q;
   logic                  BUSY;
   logic                  PERR;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [WIDTH-1:0] model_mem [DEPTH];
   logic             model_bad [DEPTH];
   logic [WIDTH-1:0] exp_q [$];
   logic             exp_perr_q [$];

   ct_f_spsram_param_init #(
      .WIDTH     (WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .SLICE     (SLICE)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .CEN (CEN),
      .GWEN(GWEN),
      .WEN (WEN),
      .A   (A),
      .D   (D),
      .Q   (Q),
      .BUSY(BUSY),
      .PERR(PERR)
   );

   // Free-running clock, period 10
   always #5 CLK = ~CLK;

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: timed out, got no end, expected end of test");
      $fatal(1, "[TB] timeout");
   end

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge
   task automatic applyStimulus(input logic cen, input logic gwen, input logic [WIDTH-1:0] wen,
                                input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
      @(negedge CLK);
      CEN  = cen;
      GWEN = gwen;
      WEN  = wen;
      A    = a;
      D    = d;
   endtask

   task automatic doIdle();
      applyStimulus(1'b1, 1'b1, '1, '0, '0);
   endtask

   task automatic doWrite(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] wen);
      applyStimulus(1'b0, 1'b0, wen, a, d);
      for (int k = 0; k < NSLICE; k++) begin
         if (!wen[k*SLICE+SLICE-1]) begin
            model_mem[a][k*SLICE +: SLICE] = d[k*SLICE +: SLICE];
            if (k == 0) model_bad[a] = 1'b0;
         end
      end
   endtask

   task automatic doRead(input logic [ADDR_WIDTH-1:0] a);
      applyStimulus(1'b0, 1'b1, '1, a, '0);
      exp_q.push_back(model_mem[a]);
      exp_perr_q.push_back(model_bad[a]);
   endtask

   task automatic clearModel();
      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i] = '0;
         model_bad[i] = 1'b0;
      end
   endtask

   // Count BUSY cycles from the current falling edge, bounded
   task automatic waitSweep(input int limit, output int n);
      n = 0;
      while (BUSY === 1'b1 && n < limit) begin
         n++;
         @(negedge CLK);
      end
   endtask

   // Scoreboard: an accepted read produces Q/PERR one cycle later
   always @(posedge CLK) begin
      if (RST === 1'b0 && BUSY === 1'b0 && CEN === 1'b0 && GWEN === 1'b1) begin
         #1;
         if (exp_q.size() == 0) begin
            checkOutput("sb_underflow", 64'd1, 64'd0);
         end else begin
            checkOutput("q_read", {10'd0, Q}, {10'd0, exp_q.pop_front()});
            checkOutput("perr_read", {63'd0, PERR}, {63'd0, exp_perr_q.pop_front()});
         end
      end
   end

   initial begin
      int n;
      clearModel();
      CEN  = 1'b1;
      GWEN = 1'b1;
      WEN  = '1;
      A    = '0;
      D    = '0;
      RST  = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      checkOutput("reset_busy", {63'd0, BUSY}, 64'd1);
      checkOutput("reset_perr", {63'd0, PERR}, 64'd0);

      // Sweep, with a write attempt at A=0x03 that must be ignored
      n = 0;
      while (BUSY === 1'b1 && n < 1000) begin
         if (n == 10) begin
            CEN = 1'b0; GWEN = 1'b0; WEN = '0; A = 8'h03; D = 54'hFF;
         end else if (n == 11) begin
            CEN = 1'b1; GWEN = 1'b1; WEN = '1;
         end
         if (n == 20) checkOutput("perr_busy", {63'd0, PERR}, 64'd0);
         n++;
         @(negedge CLK);
      end
      checkOutput("busy_cycles", 64'(n), 64'd256);

      // Every entry reads back zero after the sweep
      for (int i = 0; i < DEPTH; i++) doRead(i[ADDR_WIDTH-1:0]);
      doIdle();

      // Full write, read back, then Q must hold through idle cycles
      doWrite(8'h05, 54'h2A_AAAA_5555_5555, '0);
      doRead(8'h05);
      doIdle();
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("q_hold", {10'd0, Q}, {10'd0, model_mem[5]});
      end

      // Slice mask: only the upper slice is written; write visible next cycle
      doWrite(8'h10, '1, 54'd1 << 26);
      doIdle();
      checkOutput("raw_visible", {10'd0, Q}, {10'd0, model_mem[8'h10]});
      doRead(8'h10);
      // Lower slice only, upper keeps old pattern
      doWrite(8'h05, '0, 54'd1 << 53);
      doRead(8'h05);
      doRead(8'h10);
      doWrite(8'h80, 54'h0_1234_5678_9ABC, '0);
      doRead(8'h80);
      doIdle();

      // Reset during READY, then again 100 cycles into the sweep
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      waitSweep(100, n);
      checkOutput("busy_at_100", {63'd0, BUSY}, 64'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      clearModel();
      waitSweep(1000, n);
      checkOutput("busy_restart", 64'(n), 64'd256);
      doRead(8'h80);
      doRead(8'h05);
      doRead(8'h03);
      doIdle();

`ifdef CT_F_SPSRAM_PARITY_EN
      // Corrupt the stored parity of slice 0 at 0x20 through the backdoor
      doWrite(8'h20, 54'h0_1234_5678_9ABC, '0);
      doWrite(8'h21, 54'h3_0F0F_0F0F_0F0F, '0);
      doIdle();
      dut.g_slice[0].u_ram.mem[8'h20][SLICE] = ~dut.g_slice[0].u_ram.mem[8'h20][SLICE];
      model_bad[8'h20] = 1'b1;
      doRead(8'h20);
      doIdle();
      @(negedge CLK);
      checkOutput("perr_hold", {63'd0, PERR}, 64'd1);
      doRead(8'h21);
      doIdle();
`endif

      repeat (3) @(negedge CLK);
      checkOutput("sb_drain", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
